bus_bridge: RTL and testbench
=============================

BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 clock  in  1  sole clock; all state updates on posedge clock.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 if_req_valid  in  1  fetch request; held with if_addr stable until if_resp_valid.
REQ-004 if_addr  in  64  fetch byte address; 4-byte aligned.
REQ-005 if_resp_valid  out  1  one-cycle pulse; if_inst valid in that cycle.
REQ-006 if_inst  out  32  fetched instruction word.
REQ-007 mem_req_valid  in  1  load/store request; held with all mem_* inputs stable until mem_resp_valid.
REQ-008 mem_req_wen  in  1  1 = store, 0 = load.
REQ-009 mem_addr  in  64  data byte address.
REQ-010 mem_wdata  in  64  store data, already lane-aligned to the 8-byte beat.
REQ-011 mem_wstrb  in  8  store byte enables, lane-aligned.
REQ-012 mem_resp_valid  out  1  one-cycle pulse; load data valid or store complete.
REQ-013 mem_rdata  out  64  full 8-byte beat of the last load.
REQ-014 bus_req_valid  out  1  bus request valid.
REQ-015 bus_req_ready  in  1  bus accepts request.
REQ-016 bus_req_addr  out  64  beat address, low 3 bits zero.
REQ-017 bus_req_wen  out  1  bus write.
REQ-018 bus_req_wdata  out  64  bus write data.
REQ-019 bus_req_wstrb  out  8  bus byte enables; 8'h00 on reads.
REQ-020 bus_resp_valid  in  1  bus response valid.
REQ-021 bus_resp_ready  out  1  bridge accepts response.
REQ-022 bus_resp_rdata  in  64  bus read data.

Function
REQ-023 FSM states IDLE, REQ, WAIT, DONE; exactly one transaction in flight.
REQ-024 IDLE: if mem_req_valid, grant mem; else if if_req_valid, grant if; else stay IDLE. Mem has fixed priority.
REQ-025 On grant, latch port id, {addr[63:3],3'b000}, addr[2], wen (0 for fetch), wdata, wstrb (8'h00 on reads); go to REQ.
REQ-026 REQ: bus_req_valid=1 with latched fields stable; on bus_req_valid&&bus_req_ready, go to WAIT next cycle.
REQ-027 WAIT: bus_resp_ready=1; on bus_resp_valid, capture bus_resp_rdata, go to DONE. Writes also wait for a response; its data is discarded.
REQ-028 DONE: pulse the granted port's resp_valid for exactly one cycle, then return to IDLE. No grant is made in DONE, so a request dropped after its response is never reissued.
REQ-029 if_inst = latched addr[2] ? rdata[63:32] : rdata[31:0]. It is registered and holds until the next fetch response.
REQ-030 mem_rdata updates only on load responses and holds otherwise. Stores leave it unchanged.
REQ-031 Minimum latency with ready/valid asserted immediately: request sampled in IDLE cycle N, response pulse in cycle N+3.
REQ-032 The non-granted port waits unserviced; it is arbitrated at the next IDLE, with no starvation bound guaranteed for if.
REQ-033 bus_req_valid is 0 outside REQ, and bus_resp_ready is 0 outside WAIT.

Reset
REQ-034 With reset high at a posedge, from the next cycle: state=IDLE, bus_req_valid=0, bus_resp_ready=0, if_resp_valid=0, mem_resp_valid=0, if_inst=0, mem_rdata=0, latched fields=0.
REQ-035 Reset in any state, including REQ or WAIT, aborts the transaction with no resp pulse. The bus side is reset in the same cycle.

Verification
REQ-036 Fetch if_addr=0x80000004, ready and resp immediate, rdata=0x00000013_12345678 -> bus_req_addr=0x80000000, wstrb=0x00; if_inst=0x00000013 pulses in cycle N+3.
REQ-037 if and mem load asserted in the same cycle -> mem served first (mem_resp_valid pulse), then if; never both pulses in one cycle.
REQ-038 Store mem_addr=0x80001008, wdata=0xAABB, wstrb=0x0F, bus_req_ready low 3 cycles -> bus_req_* stable all 4 REQ cycles, wen=1; mem_resp_valid pulses; mem_rdata unchanged.
REQ-039 bus_resp_valid delayed 5 cycles -> bus_resp_ready held 1 throughout WAIT; single resp pulse afterwards.
REQ-040 Reset asserted in WAIT -> next cycle all outputs 0, IDLE; a later bus_resp_valid is ignored and produces no pulse.

Source files
------------

// File: rtl/bus_bridge.sv
// Bridges a fetch port and a load/store port onto one ready/valid beat bus.
// Memory port has fixed priority; a single transaction is in flight at a time.
module bus_bridge (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    input  logic [63:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_inst,
    input  logic        mem_req_valid,
    input  logic        mem_req_wen,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [7:0]  mem_wstrb,
    output logic        mem_resp_valid,
    output logic [63:0] mem_rdata,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [63:0] bus_req_addr,
    output logic        bus_req_wen,
    output logic [63:0] bus_req_wdata,
    output logic [7:0]  bus_req_wstrb,
    input  logic        bus_resp_valid,
    output logic        bus_resp_ready,
    input  logic [63:0] bus_resp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic        port_mem_q, port_mem_d;
    logic        word_hi_q, word_hi_d;
    logic        wen_q, wen_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [63:0] mem_rdata_q, mem_rdata_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            port_mem_q  <= 1'b0;
            word_hi_q   <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            port_mem_q  <= port_mem_d;
            word_hi_q   <= word_hi_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        port_mem_d     = port_mem_q;
        word_hi_d      = word_hi_q;
        wen_d          = wen_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        if_inst_d      = if_inst_q;
        mem_rdata_d    = mem_rdata_q;
        bus_req_valid  = 1'b0;
        bus_resp_ready = 1'b0;
        if_resp_valid  = 1'b0;
        mem_resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    state_d    = REQ;
                    port_mem_d = 1'b1;
                    addr_d     = mem_addr & ~64'h7;
                    word_hi_d  = mem_addr[2];
                    wen_d      = mem_req_wen;
                    wdata_d    = mem_wdata;
                    wstrb_d    = mem_req_wen ? mem_wstrb : 8'h00;
                end else if (if_req_valid) begin
                    state_d    = REQ;
                    port_mem_d = 1'b0;
                    addr_d     = if_addr & ~64'h7;
                    word_hi_d  = if_addr[2];
                    wen_d      = 1'b0;
                    wdata_d    = '0;
                    wstrb_d    = 8'h00;
                end
            end
            REQ: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) state_d = WAIT;
            end
            WAIT: begin
                bus_resp_ready = 1'b1;
                if (bus_resp_valid) begin
                    state_d = DONE;
                    // Write responses only complete the transaction; their data is dropped.
                    if (!port_mem_q)
                        if_inst_d = word_hi_q ? bus_resp_rdata[63:32] : bus_resp_rdata[31:0];
                    else if (!wen_q)
                        mem_rdata_d = bus_resp_rdata;
                end
            end
            DONE: begin
                if_resp_valid  = !port_mem_q;
                mem_resp_valid = port_mem_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_req_addr  = addr_q;
    assign bus_req_wen   = wen_q;
    assign bus_req_wdata = wdata_q;
    assign bus_req_wstrb = wstrb_q;
    assign if_inst       = if_inst_q;
    assign mem_rdata     = mem_rdata_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Bench for bus_bridge: the bench plays both requesters and the bus slave,
// predicting bus fields and port results from the request/response data.
module tb_bus_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic [31:0] if_inst;
    logic        mem_req_valid;
    logic        mem_req_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [63:0] bus_req_addr;
    logic        bus_req_wen;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_wstrb;
    logic        bus_resp_valid;
    logic        bus_resp_ready;
    logic [63:0] bus_resp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what each port's result register must hold.
    logic [31:0] exp_if_inst   = '0;
    logic [63:0] exp_mem_rdata = '0;

    bus_bridge dut (
        .clock          (clock),
        .reset          (reset),
        .if_req_valid   (if_req_valid),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_inst        (if_inst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_wen    (mem_req_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wen    (bus_req_wen),
        .bus_req_wdata  (bus_req_wdata),
        .bus_req_wstrb  (bus_req_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_ready (bus_resp_ready),
        .bus_resp_rdata (bus_resp_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic drive_mem(input bit wen, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [7:0] wstrb);
        mem_req_valid = 1'b1;
        mem_req_wen   = wen;
        mem_addr      = addr;
        mem_wdata     = wdata;
        mem_wstrb     = wstrb;
    endtask

    task automatic drive_if(input logic [63:0] addr);
        if_req_valid = 1'b1;
        if_addr      = addr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, 64'(bus_req_valid), 64'd0);
        chk({tag, "_resp_ready"}, 64'(bus_resp_ready), 64'd0);
        chk({tag, "_pulses"}, 64'({if_resp_valid, mem_resp_valid}), 64'd0);
        chk({tag, "_if_inst"}, 64'(if_inst), 64'd0);
        chk({tag, "_mem_rdata"}, mem_rdata, 64'd0);
        chk({tag, "_req_addr"}, bus_req_addr, 64'd0);
        chk({tag, "_req_wen"}, 64'(bus_req_wen), 64'd0);
        chk({tag, "_req_wdata"}, bus_req_wdata, 64'd0);
        chk({tag, "_req_wstrb"}, 64'(bus_req_wstrb), 64'd0);
    endtask

    // Serves one granted transaction as bus slave. Called at a negedge right
    // after the request is visible; pre = negedges until bus_req_valid expected.
    task automatic do_txn(input bit is_mem, input bit wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wstrb,
                          input int pre, input int rdly, input int sdly,
                          input logic [63:0] rdata);
        int          n;
        bit          ewen;
        logic [63:0] eaddr;
        logic [7:0]  estrb;
        eaddr = {addr[63:3], 3'b000};
        ewen  = is_mem && wen;
        estrb = ewen ? wstrb : 8'h00;
        n = 0;
        while (1) begin
            @(negedge clock);
            n++;
            if (bus_req_valid || n >= 20) break;
        end
        chk("req_latency", 64'(n), 64'(pre));
        if (!bus_req_valid) return;
        for (int i = 0; i <= rdly; i++) begin
            if (i > 0) @(negedge clock);
            chk("req_valid", 64'(bus_req_valid), 64'd1);
            chk("req_addr", bus_req_addr, eaddr);
            chk("req_wen", 64'(bus_req_wen), 64'(ewen));
            chk("req_wstrb", 64'(bus_req_wstrb), 64'(estrb));
            if (ewen) chk("req_wdata", bus_req_wdata, wdata);
            chk("resp_ready_in_req", 64'(bus_resp_ready), 64'd0);
            chk("pulse_in_req", 64'({if_resp_valid, mem_resp_valid}), 64'd0);
        end
        bus_req_ready = 1'b1;
        @(negedge clock);
        bus_req_ready = 1'b0;
        for (int i = 0; i <= sdly; i++) begin
            if (i > 0) @(negedge clock);
            chk("resp_ready_in_wait", 64'(bus_resp_ready), 64'd1);
            chk("req_valid_in_wait", 64'(bus_req_valid), 64'd0);
            chk("pulse_in_wait", 64'({if_resp_valid, mem_resp_valid}), 64'd0);
        end
        bus_resp_valid = 1'b1;
        bus_resp_rdata = rdata;
        @(negedge clock);
        bus_resp_valid = 1'b0;
        bus_resp_rdata = rnd64();
        if (!is_mem) exp_if_inst = addr[2] ? rdata[63:32] : rdata[31:0];
        else if (!wen) exp_mem_rdata = rdata;
        chk("if_pulse", 64'(if_resp_valid), 64'(!is_mem));
        chk("mem_pulse", 64'(mem_resp_valid), 64'(is_mem));
        chk("if_inst", 64'(if_inst), 64'(exp_if_inst));
        chk("mem_rdata", mem_rdata, exp_mem_rdata);
        if (is_mem) mem_req_valid = 1'b0;
        else        if_req_valid  = 1'b0;
        @(negedge clock);
        chk("pulse_once", 64'({if_resp_valid, mem_resp_valid}), 64'd0);
        chk("idle_req_valid", 64'(bus_req_valid), 64'd0);
        chk("idle_resp_ready", 64'(bus_resp_ready), 64'd0);
        chk("hold_if_inst", 64'(if_inst), 64'(exp_if_inst));
        chk("hold_mem_rdata", mem_rdata, exp_mem_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a, d, ia;
        logic [7:0]  s;
        bit          w;
        int          sc;

        reset          = 1'b1;
        if_req_valid   = 1'b0;
        if_addr        = '0;
        mem_req_valid  = 1'b0;
        mem_req_wen    = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wstrb      = '0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = '0;
        repeat (2) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("quiet_req_valid", 64'(bus_req_valid), 64'd0);
        end

        // Fetch of the upper word of a beat, zero-wait bus.
        drive_if(64'h0000_0000_8000_0004);
        do_txn(1'b0, 1'b0, 64'h0000_0000_8000_0004, '0, '0, 1, 0, 0, 64'h00000013_12345678);
        chk("fetch_hi_word", 64'(if_inst), 64'h0000_0013);

        // Simultaneous requests: memory load first, fetch afterwards.
        drive_mem(1'b0, 64'h0000_0000_8000_2010, rnd64(), 8'hFF);
        drive_if(64'h0000_0000_8000_0100);
        do_txn(1'b1, 1'b0, 64'h0000_0000_8000_2010, '0, 8'hFF, 1, 0, 0, 64'h1111_2222_3333_4444);
        do_txn(1'b0, 1'b0, 64'h0000_0000_8000_0100, '0, '0, 1, 0, 0, 64'h5555_6666_7777_8888);
        chk("fetch_lo_word", 64'(if_inst), 64'h7777_8888);

        // Store held off by the bus for three cycles.
        drive_mem(1'b1, 64'h0000_0000_8000_1008, 64'hAABB, 8'h0F);
        do_txn(1'b1, 1'b1, 64'h0000_0000_8000_1008, 64'hAABB, 8'h0F, 1, 3, 0, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("store_keeps_rdata", mem_rdata, 64'h1111_2222_3333_4444);

        // Slow response.
        drive_mem(1'b0, 64'h0000_0000_8000_3000, '0, '0);
        do_txn(1'b1, 1'b0, 64'h0000_0000_8000_3000, '0, '0, 1, 0, 5, 64'h0123_4567_89AB_CDEF);

        for (int it = 0; it < 40; it++) begin
            sc = $urandom_range(0, 2);
            a  = rnd64();
            d  = rnd64();
            s  = 8'($urandom());
            w  = 1'($urandom());
            ia = rnd64() & ~64'h3;
            if (sc != 1) drive_mem(w, a, d, s);
            if (sc != 0) drive_if(ia);
            if (sc != 1)
                do_txn(1'b1, w, a, d, s, 1, $urandom_range(0, 3), $urandom_range(0, 3), rnd64());
            if (sc != 0)
                do_txn(1'b0, 1'b0, ia, '0, '0, 1, $urandom_range(0, 3), $urandom_range(0, 3), rnd64());
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                chk("gap_req_valid", 64'(bus_req_valid), 64'd0);
            end
        end

        // Reset while waiting for the response aborts the load.
        drive_mem(1'b0, 64'h0000_0000_8000_4000, '0, '0);
        @(negedge clock);
        chk("abort_in_req", 64'(bus_req_valid), 64'd1);
        bus_req_ready = 1'b1;
        @(negedge clock);
        bus_req_ready = 1'b0;
        chk("abort_in_wait", 64'(bus_resp_ready), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset         = 1'b0;
        mem_req_valid = 1'b0;
        exp_if_inst   = '0;
        exp_mem_rdata = '0;
        chk_all_zero("abort");
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 64'hFFFF_0000_FFFF_0000;
        repeat (3) begin
            @(negedge clock);
            chk("late_resp_pulse", 64'({if_resp_valid, mem_resp_valid}), 64'd0);
            chk("late_resp_ready", 64'(bus_resp_ready), 64'd0);
            chk("late_resp_rdata", mem_rdata, exp_mem_rdata);
        end
        bus_resp_valid = 1'b0;

        // Bridge still works after the abort.
        drive_if(64'h0000_0000_9000_0004);
        do_txn(1'b0, 1'b0, 64'h0000_0000_9000_0004, '0, '0, 1, 1, 1, 64'hCAFE_F00D_0000_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
